pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline (F/D/E/M/W). It merges three request sources into one consistent set of per-stage enable/flush controls, plus the PC enable:
- the hazard detector's load-use request
- the EX-stage branch redirect
- the M-stage data-memory handshake

It also provides a debug halt/single-step mode and a data-memory timeout. It sits beside the pipeline registers and drives all of their enable/flush pins.

---
 rtl/pipeline_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage F/D/E/M/W pipeline.
// Merges load-use, branch-redirect and data-memory-wait requests into one
// consistent set of pipeline-register enable/flush controls plus PC enable.
// It also provides debug halt/single-step and a data-memory timeout.
//
// Optional feature macro: PIPELINE_PERF_CNT_EN
//   defined   -> stall_cycles / flush_count are saturating performance counters
//   undefined -> both outputs are tied to 0 and no counter flops exist
//
// Memory handshake: mem_req is held by the M stage for as long as its access
// is outstanding. mem_ack marks the single cycle in which the access
// completes. A cycle with mem_req=1 and mem_ack=0 freezes everything
// upstream of W. A cycle with mem_ack=1 lets the pipeline advance.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_use_hazard,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic             pc_enable,
  output logic             IF_ID_enable,
  output logic             IF_ID_flush,
  output logic             ID_EX_enable,
  output logic             ID_EX_flush,
  output logic             EX_ME_enable,
  output logic             EX_ME_flush,
  output logic             ME_WB_enable,
  output logic             ME_WB_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2,
    S_STEP     = 2'd3
  } state_t;

  // Control vector layout, MSB first:
  // pc, IF_ID en/flush, ID_EX en/flush, EX_ME en/flush, ME_WB en/flush
  localparam logic [8:0] C_NORMAL  = 9'b1_10_10_10_10;
  localparam logic [8:0] C_MEM     = 9'b0_00_00_00_11; // bubble into W so it does not re-retire
  localparam logic [8:0] C_HALT    = 9'b0_00_00_00_00;
  localparam logic [8:0] C_BRANCH  = 9'b1_11_11_10_10;
  localparam logic [8:0] C_LD_USE  = 9'b0_00_11_10_10;
  localparam logic [8:0] C_TIMEOUT = 9'b0_00_00_11_11; // abandoned access dropped from E/M

  localparam logic [7:0] TO_LIMIT = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_to_cnt;
  logic [7:0] w_to_cnt_nxt;
  logic       r_mem_timeout;
  logic       w_timeout_set;
  logic       w_mem_stall;
  logic [8:0] w_ctrl;
  logic [8:0] w_ctrl_out;

  // Priority-encoded RUN rules: mem wait > halt > branch > load-use.
  function automatic logic [8:0] run_rules(input logic mem_stall, input logic halt_req,
                                           input logic br, input logic ld);
    if (mem_stall)     return C_MEM;
    else if (halt_req) return C_HALT;
    else if (br)       return C_BRANCH;
    else if (ld)       return C_LD_USE;
    else               return C_NORMAL;
  endfunction

  assign w_mem_stall = mem_req & ~mem_ack;

  // State, timeout counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_to_cnt      <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      if (w_timeout_set) r_mem_timeout <= 1'b1;
    end
  end

  // Mealy next-state and control decode so stalls act in the same cycle.
  always_comb begin
    w_ctrl        = C_NORMAL;
    w_state_nxt   = r_state;
    w_to_cnt_nxt  = r_to_cnt;
    w_timeout_set = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_ctrl = run_rules(w_mem_stall, dbg_halt, br_taken, ld_use_hazard);
        if (w_mem_stall) begin
          w_state_nxt  = S_MEM_WAIT;
          w_to_cnt_nxt = 8'd1;
        end else if (dbg_halt) begin
          w_state_nxt = S_HALT;
        end
      end
      S_STEP: begin
        // The step cycle itself must advance, so the still-asserted halt
        // request is not allowed to freeze it.
        w_ctrl = run_rules(w_mem_stall, 1'b0, br_taken, ld_use_hazard);
        if (w_mem_stall) begin
          w_state_nxt  = S_MEM_WAIT;
          w_to_cnt_nxt = 8'd1;
        end else begin
          w_state_nxt = S_HALT;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          w_ctrl       = run_rules(1'b0, dbg_halt, br_taken, ld_use_hazard);
          w_state_nxt  = S_RUN;
          w_to_cnt_nxt = 8'd0;
        end else if (r_to_cnt == TO_LIMIT) begin
          w_ctrl        = C_TIMEOUT;
          w_timeout_set = 1'b1;
          w_state_nxt   = S_RUN;
          w_to_cnt_nxt  = 8'd0;
        end else begin
          w_ctrl       = C_MEM;
          w_to_cnt_nxt = r_to_cnt + 8'd1;
        end
      end
      S_HALT: begin
        w_ctrl = C_HALT;
        if (dbg_step)       w_state_nxt = S_STEP;
        else if (!dbg_halt) w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // While reset is held the controls show the normal set regardless of inputs.
  assign w_ctrl_out = rst_n ? w_ctrl : C_NORMAL;

  assign pc_enable    = w_ctrl_out[8];
  assign IF_ID_enable = w_ctrl_out[7];
  assign IF_ID_flush  = w_ctrl_out[6];
  assign ID_EX_enable = w_ctrl_out[5];
  assign ID_EX_flush  = w_ctrl_out[4];
  assign EX_ME_enable = w_ctrl_out[3];
  assign EX_ME_flush  = w_ctrl_out[2];
  assign ME_WB_enable = w_ctrl_out[1];
  assign ME_WB_flush  = w_ctrl_out[0];
  assign halted       = (r_state == S_HALT);
  assign mem_timeout  = r_mem_timeout;

`ifdef PIPELINE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating counters of PC-stalled cycles and branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctrl_out[8] && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_ctrl_out[6] && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
